// File: rtl/n64_bit_receiver.sv
// n64_bit_receiver
//
// Decodes the N64 controller single-wire bit stream. Each bit is a low pulse
// followed by a high pulse. A short low is a 1 and a long low is a 0. After
// WORD_BITS data bits, a stop bit's low pulse completes the frame.
//
// Ports
//   clk         single clock, all logic on its rising edge
//   Reset       synchronous, active-high reset
//   Enable      receiver armed when high; dropping it aborts a frame in progress
//   Data_In     raw open-drain line, asynchronous, idles high
//   Data_Out    last completed word, first received bit in the MSB
//   Data_Valid  one-cycle pulse when Data_Out updates
//   Frame_Err   one-cycle pulse on an inter-bit timeout or an over-long low
//   Busy        high whenever the receiver is not idle
//
// Configuration
//   N64_RX_GLITCH_FILTER_EN  when defined, the synchronized line changes only
//                            after 3 equal consecutive samples. This rejects
//                            pulses shorter than 3 cycles and adds 2 cycles
//                            of latency.
module n64_bit_receiver #(
  parameter int CLK_PER_US = 4,
  parameter int WORD_BITS  = 8,
  parameter int TIMEOUT_US = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Data_In,
  output logic [WORD_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic                 Frame_Err,
  output logic                 Busy
);

  localparam int LOW_MAX    = 4 * CLK_PER_US;
  localparam int BIT_THRESH = 2 * CLK_PER_US;
  localparam int HIGH_MAX   = TIMEOUT_US * CLK_PER_US;

  localparam int LOW_W  = $clog2(LOW_MAX + 1);
  localparam int HIGH_W = $clog2(HIGH_MAX + 1);
  localparam int BIT_W  = $clog2(WORD_BITS + 1);

  localparam logic [LOW_W-1:0]  LOW_MAX_C    = LOW_W'(LOW_MAX);
  localparam logic [LOW_W-1:0]  LOW_ERR_AT   = LOW_W'(LOW_MAX - 1);
  localparam logic [LOW_W-1:0]  BIT_THRESH_C = LOW_W'(BIT_THRESH);
  localparam logic [HIGH_W-1:0] HIGH_MAX_C   = HIGH_W'(HIGH_MAX);
  localparam logic [HIGH_W-1:0] HIGH_ERR_AT  = HIGH_W'(HIGH_MAX - 1);
  localparam logic [BIT_W-1:0]  WORD_BITS_C  = BIT_W'(WORD_BITS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_LOW  = 2'd1,
    MEAS_HIGH = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  // Two-flop synchronizer. The flops reset to 1 because the line idles high.
  logic sync1, sync2;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Data_In;
      sync2 <= sync1;
    end
  end

  logic line_s;

`ifdef N64_RX_GLITCH_FILTER_EN
  // The last two synchronizer outputs are kept in hist1 and hist2. The line
  // follows sync2 only when all three samples agree. Otherwise it holds its
  // previously filtered level.
  logic hist1, hist2, line_f;

  // NOTE: this mux has both arms assigned by a continuous assign, so it
  // cannot infer a latch; the held value lives in the line_f flop.
  assign line_s = (sync2 == hist1 && hist1 == hist2) ? sync2 : line_f;

  always_ff @(posedge clk) begin
    if (Reset) begin
      hist1  <= 1'b1;
      hist2  <= 1'b1;
      line_f <= 1'b1;
    end else begin
      hist1  <= sync2;
      hist2  <= hist1;
      line_f <= line_s;
    end
  end
`else
  assign line_s = sync2;
`endif

  // Edge detection on the synchronized (and optionally filtered) line.
  logic line_prev;
  logic fall, rise;

  assign fall = line_prev & ~line_s;
  assign rise = ~line_prev & line_s;

  always_ff @(posedge clk) begin
    if (Reset) line_prev <= 1'b1;
    else       line_prev <= line_s;
  end

  state_t                state;
  logic [LOW_W-1:0]      low_cnt;
  logic [HIGH_W-1:0]     high_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [WORD_BITS-1:0]  shift_reg;
  logic                  bit_val;

  // A low shorter than two microseconds encodes a 1.
  assign bit_val = (low_cnt < BIT_THRESH_C);

  always_ff @(posedge clk) begin
    if (Reset) begin
      // NOTE: Data_Out, shift_reg and the counters are ordinary flops, not a
      // memory array, so they are all cleared here together with the FSM.
      state      <= IDLE;
      Busy       <= 1'b0;
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
      shift_reg  <= '0;
      low_cnt    <= '0;
      high_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;

      if (state != IDLE && !Enable) begin
        // Silent abort: the partial word is dropped without any pulse.
        state <= IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Enable && fall) begin
              state     <= MEAS_LOW;
              Busy      <= 1'b1;
              low_cnt   <= LOW_W'(1);
              high_cnt  <= '0;
              bit_cnt   <= '0;
              shift_reg <= '0;
            end
          end

          MEAS_LOW: begin
            // On entry to this state the line was just low, so any high
            // sample seen here is a rising edge.
            if (rise) begin
              if (bit_cnt == WORD_BITS_C) begin
                // Stop bit: the value of its low is ignored.
                Data_Out   <= shift_reg;
                Data_Valid <= 1'b1;
                state      <= IDLE;
                Busy       <= 1'b0;
              end else begin
                shift_reg <= (shift_reg << 1) | WORD_BITS'(bit_val);
                bit_cnt   <= bit_cnt + BIT_W'(1);
                high_cnt  <= HIGH_W'(1);
                state     <= MEAS_HIGH;
              end
            end else begin
              if (low_cnt != LOW_MAX_C) low_cnt <= low_cnt + LOW_W'(1);
              if (low_cnt == LOW_ERR_AT) begin
                // The line is held low too long. Wait for it to go high so
                // that the rest of this pulse cannot start a new frame.
                Frame_Err <= 1'b1;
                state     <= DRAIN;
              end
            end
          end

          MEAS_HIGH: begin
            if (fall) begin
              state    <= MEAS_LOW;
              low_cnt  <= LOW_W'(1);
              high_cnt <= '0;
            end else begin
              if (high_cnt != HIGH_MAX_C) high_cnt <= high_cnt + HIGH_W'(1);
              if (high_cnt == HIGH_ERR_AT) begin
                Frame_Err <= 1'b1;
                state     <= IDLE;
                Busy      <= 1'b0;
              end
            end
          end

          DRAIN: begin
            if (line_s) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/n64_bit_receiver.md
N64_BIT_RECEIVER -- requirements
Module: n64_bit_receiver

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 4, clk cycles per microsecond of line time.
REQ-002 SHALL have parameter WORD_BITS, default 8, data bits per frame (range 1..32).
REQ-003 SHALL have parameter TIMEOUT_US, default 8, maximum line-high time between bits mid-frame.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Enable  input  1  receiver armed when high.
REQ-007 SHALL have port Data_In  input  1  raw open-drain N64 line, asynchronous, idles high.
REQ-008 SHALL have port Data_Out  output  WORD_BITS  last completed word, MSB received first.
REQ-009 SHALL have port Data_Valid  output  1  one-cycle pulse when Data_Out updates.
REQ-010 SHALL have port Frame_Err  output  1  one-cycle pulse on timeout or over-long low.
REQ-011 SHALL have port Busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass Data_In through a 2-flop synchronizer; every edge and count uses the synchronized value (line_s).
REQ-013 SHALL implement states IDLE, MEAS_LOW, MEAS_HIGH, DRAIN.
REQ-014 IDLE: on line_s falling edge with Enable=1 -> MEAS_LOW, low_cnt=1, bit_cnt=0; edges with Enable=0 SHALL be ignored.
REQ-015 MEAS_LOW: low_cnt increments each low cycle, saturating at LOW_MAX=4*CLK_PER_US.
REQ-016 MEAS_LOW, low_cnt reaching LOW_MAX -> Frame_Err pulse, word discarded, -> DRAIN.
REQ-017 MEAS_LOW, on rising edge with bit_cnt<WORD_BITS: bit = 1 if low_cnt < 2*CLK_PER_US, else 0; bit shifted into the LSB of shift_reg; bit_cnt++; high_cnt=1; -> MEAS_HIGH.
REQ-018 MEAS_LOW, on rising edge with bit_cnt==WORD_BITS (stop bit, value ignored): Data_Out<=shift_reg and Data_Valid=1 in the next cycle; -> IDLE.
REQ-019 MEAS_HIGH: on falling edge -> MEAS_LOW, low_cnt=1, high_cnt cleared.
REQ-020 MEAS_HIGH: high_cnt reaching TIMEOUT_US*CLK_PER_US -> Frame_Err pulse, word discarded, -> IDLE.
REQ-021 DRAIN: remain until line_s high, then -> IDLE; no bits decoded.
REQ-022 Enable falling in any non-IDLE state SHALL abort to IDLE next cycle with no Data_Valid or Frame_Err.
REQ-023 Data_Valid and Frame_Err SHALL never assert in the same cycle, and each SHALL be exactly one cycle wide.
REQ-024 Data_Out SHALL hold its value between Data_Valid pulses; discarded words SHALL not modify it.
REQ-025 Counters SHALL be sized to clog2(max count + 1) and SHALL not wrap.

Reset
REQ-026 Reset SHALL force state IDLE and Data_Out=0, Data_Valid=0, Frame_Err=0, Busy=0; it SHALL also clear shift_reg, all counters and the synchronizer flops to 1 (line idle).
REQ-027 Reset asserted mid-frame SHALL discard the partial word; the first falling edge after release SHALL start a fresh frame.

Configuration
REQ-028 Macro N64_RX_GLITCH_FILTER_EN defined: line_s SHALL change only after 3 consecutive equal synchronizer outputs, adding 2 cycles of latency; pulses shorter than 3 cycles SHALL be ignored.
REQ-029 Macro N64_RX_GLITCH_FILTER_EN undefined: line_s SHALL be the synchronizer output directly, with no filter logic.

Verification (CLK_PER_US=4, WORD_BITS=8, TIMEOUT_US=8)
REQ-030 Send 0xA5: 1 = 4 low/12 high, 0 = 12 low/4 high, then stop bit of 4 low -> Data_Out=0xA5, a single Data_Valid pulse, Frame_Err=0.
REQ-031 Threshold check: low of 7 cycles decodes as 1 and low of 8 cycles decodes as 0; frame 7,8,7,8,7,8,7,8 -> Data_Out=0xAA.
REQ-032 Three bits, then the line held high for 32 cycles -> Frame_Err pulse on the 32nd high cycle, Data_Out unchanged, Busy=0.
REQ-033 Line held low for 20 cycles -> Frame_Err when low_cnt reaches 16; no new frame starts until the line returns high.
REQ-034 Reset asserted for 1 cycle after 5 bits -> all outputs 0; a following 0x3C frame decodes as 0x3C.
REQ-035 1-cycle low glitch in IDLE -> macro defined: no Busy; macro undefined: Busy rises, followed by a Frame_Err on timeout.
